// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue
//
// Feeds the cosim checker one retirement event per cycle. Each cycle the core
// may retire up to COMMITS instructions (sparse lanes) plus one trap. The valid
// lanes are packed in ascending lane order, followed by the trap, into a
// circular buffer, and the buffer is drained one record per cycle through a
// first-word-fall-through valid/ready port. A batch that does not fit is
// dropped whole, and the drop is recorded in overflow/drop_count.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   in_valid/pc/insn/...  per-lane retirement records (lane i at slice i)
//   trap_valid/cause      trap taken this cycle, queued after the lanes
//   out_valid/out_ready   head record handshake
//   out_kind ... cause    head record fields (0 when out_valid=0)
//   count                 occupied entries
//   overflow, drop_count  sticky drop flag and saturating drop counter
module cosim_commit_queue #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMITS-1:0]        in_valid,
  input  logic [COMMITS*XLEN-1:0]   in_pc,
  input  logic [COMMITS*32-1:0]     in_insn,
  input  logic [COMMITS-1:0]        in_wen,
  input  logic [COMMITS-1:0]        in_wfp,
  input  logic [COMMITS*5-1:0]      in_waddr,
  input  logic [COMMITS*XLEN-1:0]   in_wdata,
  input  logic                      trap_valid,
  input  logic [XLEN-1:0]           trap_cause,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_kind,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_insn,
  output logic                      out_wen,
  output logic                      out_wfp,
  output logic [4:0]                out_waddr,
  output logic [XLEN-1:0]           out_wdata,
  output logic [XLEN-1:0]           out_cause,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic            mem_kind  [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_insn  [DEPTH];
  logic            mem_wen   [DEPTH];
  logic            mem_wfp   [DEPTH];
  logic [4:0]      mem_waddr [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];
  logic [XLEN-1:0] mem_cause [DEPTH];

  logic [AW-1:0] lane_idx [COMMITS];
  logic [AW-1:0] trap_idx;
  logic [AW-1:0] tail_next;
  logic [CW-1:0] n_valid;
  logic [CW-1:0] n_batch;
  logic [CW-1:0] free_slots;
  logic          admit;
  logic          drop;
  logic          pop;

  // Compaction: each valid lane takes the next slot after the previous valid
  // lane, so invalid lanes leave no holes. The trap lands right after them.
  always_comb begin
    n_valid  = '0;
    trap_idx = tail;
    for (int i = 0; i < COMMITS; i++) begin
      lane_idx[i] = trap_idx;
      if (in_valid[i]) begin
        n_valid  = n_valid + CW'(1);
        trap_idx = trap_idx + AW'(1);
      end
    end
    tail_next = trap_idx + AW'(trap_valid);
    n_batch   = n_valid + CW'(trap_valid);
  end

  // Free space is judged on the registered count only; a pop happening in the
  // same cycle does not make room for this cycle's batch.
  assign free_slots = CW'(DEPTH) - count;
  assign admit      = (n_batch != '0) && (n_batch <= free_slots);
  assign drop       = (n_batch != '0) && !admit;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (admit) begin
        tail <= tail_next;
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + (admit ? n_batch : CW'(0)) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clock) begin
    if (!reset && admit) begin
      for (int i = 0; i < COMMITS; i++) begin
        if (in_valid[i]) begin
          mem_kind[lane_idx[i]]  <= 1'b0;
          mem_pc[lane_idx[i]]    <= in_pc[i*XLEN +: XLEN];
          mem_insn[lane_idx[i]]  <= in_insn[i*32 +: 32];
          mem_wen[lane_idx[i]]   <= in_wen[i];
          mem_wfp[lane_idx[i]]   <= in_wfp[i];
          mem_waddr[lane_idx[i]] <= in_waddr[i*5 +: 5];
          mem_wdata[lane_idx[i]] <= in_wdata[i*XLEN +: XLEN];
          mem_cause[lane_idx[i]] <= '0;
        end
      end
      if (trap_valid) begin
        mem_kind[trap_idx]  <= 1'b1;
        mem_pc[trap_idx]    <= '0;
        mem_insn[trap_idx]  <= '0;
        mem_wen[trap_idx]   <= 1'b0;
        mem_wfp[trap_idx]   <= 1'b0;
        mem_waddr[trap_idx] <= '0;
        mem_wdata[trap_idx] <= '0;
        mem_cause[trap_idx] <= trap_cause;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_kind  = out_valid & mem_kind[head];
  assign out_pc    = out_valid ? mem_pc[head]    : '0;
  assign out_insn  = out_valid ? mem_insn[head]  : '0;
  assign out_wen   = out_valid & mem_wen[head];
  assign out_wfp   = out_valid & mem_wfp[head];
  assign out_waddr = out_valid ? mem_waddr[head] : '0;
  assign out_wdata = out_valid ? mem_wdata[head] : '0;
  assign out_cause = out_valid ? mem_cause[head] : '0;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// tb_cosim_commit_queue
//
// Self-checking bench for cosim_commit_queue (COMMITS=2, DEPTH=16, XLEN=64).
// A queue of records models the buffer; every cycle the full set of outputs
// is compared against the model head, plus directed constant checks.
module tb_cosim_commit_queue;

  localparam int COMMITS = 2;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 64;

  logic                    clock;
  logic                    reset;
  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS-1:0]      in_wfp;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic                    out_wfp;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [XLEN-1:0]         out_cause;
  logic [4:0]              count;
  logic                    overflow;
  logic [15:0]             drop_count;

  cosim_commit_queue #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_wen(in_wen),
    .in_wfp(in_wfp), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen), .out_wfp(out_wfp),
    .out_waddr(out_waddr), .out_wdata(out_wdata), .out_cause(out_cause),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            wen;
    logic            wfp;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] cause;
  } rec_t;

  rec_t model_q[$];
  int   model_drops;
  logic model_ovf;
  int   errors;
  int   checks;

  task automatic clear_inputs();
    in_valid   = '0;
    in_pc      = '0;
    in_insn    = '0;
    in_wen     = '0;
    in_wfp     = '0;
    in_waddr   = '0;
    in_wdata   = '0;
    trap_valid = 1'b0;
    trap_cause = '0;
  endtask

  task automatic fill_lane(input int i);
    in_pc[i*XLEN +: XLEN]    = {$urandom, $urandom};
    in_insn[i*32 +: 32]      = $urandom;
    in_wen[i]                = 1'($urandom_range(0, 1));
    in_wfp[i]                = 1'($urandom_range(0, 1));
    in_waddr[i*5 +: 5]       = 5'($urandom);
    in_wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
  endtask

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic step();
    rec_t batch[$];
    rec_t r;
    bit   do_pop;
    int   free_slots;
    @(posedge clock);
    if (reset) begin
      model_q.delete();
      model_drops = 0;
      model_ovf   = 1'b0;
    end else begin
      for (int i = 0; i < COMMITS; i++) begin
        if (in_valid[i]) begin
          r.kind  = 1'b0;
          r.pc    = in_pc[i*XLEN +: XLEN];
          r.insn  = in_insn[i*32 +: 32];
          r.wen   = in_wen[i];
          r.wfp   = in_wfp[i];
          r.waddr = in_waddr[i*5 +: 5];
          r.wdata = in_wdata[i*XLEN +: XLEN];
          r.cause = '0;
          batch.push_back(r);
        end
      end
      if (trap_valid) begin
        r.kind  = 1'b1;
        r.pc    = '0;
        r.insn  = '0;
        r.wen   = 1'b0;
        r.wfp   = 1'b0;
        r.waddr = '0;
        r.wdata = '0;
        r.cause = trap_cause;
        batch.push_back(r);
      end
      do_pop     = (model_q.size() != 0) && out_ready;
      free_slots = DEPTH - model_q.size();
      if (batch.size() > 0) begin
        if (batch.size() <= free_slots) begin
          foreach (batch[k]) model_q.push_back(batch[k]);
        end else begin
          model_ovf = 1'b1;
          if (model_drops < 65535) model_drops++;
        end
      end
      if (do_pop) void'(model_q.pop_front());
    end
    #1;
  endtask

  function automatic logic [254:0] expected_vec();
    rec_t h;
    logic v;
    h.kind = 1'b0; h.pc = '0; h.insn = '0; h.wen = 1'b0; h.wfp = 1'b0;
    h.waddr = '0; h.wdata = '0; h.cause = '0;
    v = (model_q.size() != 0);
    if (v) h = model_q[0];
    return {v, h.kind, h.pc, h.insn, h.wen, h.wfp, h.waddr, h.wdata, h.cause,
            5'(model_q.size()), model_ovf, 16'(model_drops)};
  endfunction

  function automatic logic [254:0] observed_vec();
    return {out_valid, out_kind, out_pc, out_insn, out_wen, out_wfp, out_waddr,
            out_wdata, out_cause, count, overflow, drop_count};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc%0d: got %h want %h", c, observed_vec(), expected_vec());
      end
      checks++;
      if ({out_valid, count, overflow, out_pc, out_cause} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle_zero cyc%0d: got valid=%b count=%0d ovf=%b want all 0",
                 c, out_valid, count, overflow);
      end
    end
  endtask

  task automatic test_sparse_compaction();
    logic [63:0] want_pc [3];
    want_pc[0] = 64'h8000_0004;
    want_pc[1] = 64'h8000_0008;
    want_pc[2] = 64'h8000_000C;
    out_ready = 1'b1;
    clear_inputs();
    fill_lane(0);
    in_valid = 2'b10;
    in_pc[XLEN +: XLEN] = 64'h8000_0004;
    in_insn[32 +: 32]   = 32'h0010_0093;
    in_wen[1]           = 1'b1;
    in_wfp[1]           = 1'b0;
    in_waddr[5 +: 5]    = 5'd1;
    in_wdata[XLEN +: XLEN] = 64'd1;
    step();
    clear_inputs();
    fill_lane(0);
    fill_lane(1);
    in_valid = 2'b11;
    in_pc[0 +: XLEN]    = 64'h8000_0008;
    in_pc[XLEN +: XLEN] = 64'h8000_000C;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL sparse cyc%0d: got %h want %h", c, observed_vec(), expected_vec());
      end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== want_pc[c]) begin
        errors++;
        $display("[TB] FAIL sparse_order cyc%0d: got valid=%b pc=%h want valid=1 pc=%h",
                 c, out_valid, out_pc, want_pc[c]);
      end
      step();
      clear_inputs();
    end
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL sparse_drained: got valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_trap_ordering();
    out_ready = 1'b1;
    clear_inputs();
    fill_lane(0);
    fill_lane(1);
    in_valid = 2'b01;
    in_pc[0 +: XLEN] = 64'h8000_0010;
    trap_valid = 1'b1;
    trap_cause = 64'h2;
    step();
    clear_inputs();
    checks++;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL trap_first: got %h want %h", observed_vec(), expected_vec());
    end
    checks++;
    if (out_kind !== 1'b0 || out_pc !== 64'h8000_0010 || out_cause !== 64'h0) begin
      errors++;
      $display("[TB] FAIL trap_commit_head: got kind=%b pc=%h cause=%h want 0/80000010/0",
               out_kind, out_pc, out_cause);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b1 || out_cause !== 64'h2 || out_pc !== 64'h0) begin
      errors++;
      $display("[TB] FAIL trap_record: got valid=%b kind=%b cause=%h pc=%h want 1/1/2/0",
               out_valid, out_kind, out_cause, out_pc);
    end
    step();
    checks++;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL trap_drained: got %h want %h", observed_vec(), expected_vec());
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    clear_inputs();
    fill_lane(0); fill_lane(1);
    in_valid = 2'b11;
    step();
    reset = 1'b1;
    trap_valid = 1'b1;
    trap_cause = 64'h7;
    step();
    reset = 1'b0;
    clear_inputs();
    step();
    checks++;
    if (observed_vec() !== expected_vec() || count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_overflow();
    reset = 1'b1;
    clear_inputs();
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      fill_lane(0); fill_lane(1);
      in_valid = 2'b11;
      step();
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL fill cyc%0d: got %h want %h", c, observed_vec(), expected_vec());
      end
    end
    fill_lane(0); fill_lane(1);
    in_valid = 2'b11;
    trap_valid = 1'b1;
    trap_cause = 64'h5;
    step();
    clear_inputs();
    checks++;
    if (count !== 5'd14 || overflow !== 1'b1 || drop_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL overflow_drop: got count=%0d ovf=%b drops=%0d want 14/1/1",
               count, overflow, drop_count);
    end
    checks++;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL overflow_state: got %h want %h", observed_vec(), expected_vec());
    end
    fill_lane(0); fill_lane(1);
    in_valid = 2'b11;
    step();
    clear_inputs();
    checks++;
    if (count !== 5'd16 || drop_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL fill_to_full: got count=%0d drops=%0d want 16/1", count, drop_count);
    end
    // Full and popping: the pop must not make room for this batch.
    fill_lane(0);
    in_valid = 2'b01;
    out_ready = 1'b1;
    step();
    clear_inputs();
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd15 || drop_count !== 16'd2 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pop: got count=%0d drops=%0d ovf=%b want 15/2/1",
               count, drop_count, overflow);
    end
    checks++;
    if (observed_vec() !== expected_vec()) begin
      errors++;
      $display("[TB] FAIL full_push_pop_state: got %h want %h", observed_vec(), expected_vec());
    end
  endtask

  task automatic test_wrap_around();
    int pushed;
    int cyc;
    int n;
    logic [1:0] v;
    logic t;
    reset = 1'b1;
    clear_inputs();
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    pushed = 0;
    cyc = 0;
    while (pushed < 40 && cyc < 400) begin
      clear_inputs();
      out_ready = cyc[0];
      v = 2'($urandom_range(0, 3));
      t = ($urandom_range(0, 3) == 0);
      n = $countones(v) + int'(t);
      if (model_q.size() + n > DEPTH) begin
        v = 2'b00;
        t = 1'b0;
        n = 0;
      end
      fill_lane(0); fill_lane(1);
      in_valid   = v;
      trap_valid = t;
      trap_cause = {$urandom, $urandom};
      pushed += n;
      step();
      cyc++;
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL wrap cyc%0d: got %h want %h", cyc, observed_vec(), expected_vec());
      end
    end
    checks++;
    if (pushed < 40) begin
      errors++;
      $display("[TB] FAIL wrap_budget: got %0d records pushed want 40", pushed);
    end
    clear_inputs();
    out_ready = 1'b1;
    cyc = 0;
    while (model_q.size() != 0 && cyc < 64) begin
      step();
      cyc++;
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL drain cyc%0d: got %h want %h", cyc, observed_vec(), expected_vec());
      end
    end
    step();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL wrap_end: got count=%0d valid=%b ovf=%b drops=%0d want 0/0/0/0",
               count, out_valid, overflow, drop_count);
    end
  endtask

  task automatic test_random_stress();
    for (int c = 0; c < 200; c++) begin
      clear_inputs();
      fill_lane(0); fill_lane(1);
      in_valid   = 2'($urandom_range(0, 3));
      trap_valid = ($urandom_range(0, 4) == 0);
      trap_cause = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL stress cyc%0d: got %h want %h", c, observed_vec(), expected_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_drops = 0;
    model_ovf = 1'b0;
    reset = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_sparse_compaction();
    test_trap_ordering();
    test_mid_reset();
    test_overflow();
    test_wrap_around();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
